// File: rtl/turbo_out_mux.sv
// Turbo encoder output mux: packs systematic/parity/tail bits into
// 8-bit words under valid/ready, zero-padding and tagging the last word.
module turbo_out_mux #(
   parameter int K = 40
) (
   input  logic       clk,
   input  logic       rst_N,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic       in_mode,
   input  logic       x1,
   input  logic       z1,
   input  logic       x2,
   input  logic       z2,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [7:0] out_data,
   output logic       out_last,
   output logic       err
);

   localparam int KW = (K > 1) ? $clog2(K) : 1;

   typedef enum logic [1:0] {
      S_DATA,
      S_TAIL,
      S_FLUSH
   } state_t;

   state_t      state;
   state_t      state_n;
   logic [KW-1:0] k;
   logic [1:0]  t;
   logic [15:0] acc;
   logic [15:0] acc_n;
   logic [15:0] rem;
   logic [4:0]  cnt;
   logic [4:0]  cnt_n;
   logic [4:0]  rem_cnt;
   logic [4:0]  npop;
   logic [2:0]  npush;
   logic [3:0]  nb;
   logic [7:0]  ld_data;
   logic        fire_in;
   logic        out_fire;
   logic        slot;
   logic        ld_full;
   logic        ld_part;
   logic        ld;
   logic        ld_last;
   logic        k_last;

   always_comb begin
      k_last   = (k == KW'(K - 1));
      fire_in  = in_valid && in_ready;
      out_fire = out_valid && out_ready;
      slot     = !out_valid || out_ready;
      ld_full  = slot && (cnt >= 5'd8);
      ld_part  = slot && (state == S_FLUSH) && (cnt != 5'd0) && !ld_full;
      ld       = ld_full || ld_part;
      ld_last  = (state == S_FLUSH) && (cnt <= 5'd8);
      // Bits below cnt are kept zero, but mask the tail word explicitly.
      ld_data  = acc[15:8] & (ld_full ? 8'hFF : ~(8'hFF >> cnt));
      npop     = ld_full ? 5'd8 : (ld_part ? cnt : 5'd0);
      rem      = acc << npop;
      rem_cnt  = cnt - npop;
      nb       = (state == S_TAIL) ? {x1, z1, x2, z2} : {x1, z1, z2, 1'b0};
      npush    = !fire_in ? 3'd0 : ((state == S_TAIL) ? 3'd4 : 3'd3);
      acc_n    = rem | (fire_in ? ({nb, 12'd0} >> rem_cnt) : 16'd0);
      cnt_n    = rem_cnt + {2'b00, npush};
   end

   always_ff @(posedge clk) begin
      if (!rst_N) state <= S_DATA;
      else        state <= state_n;
   end

   always_comb begin
      state_n = state;
      unique case (state)
         S_DATA:  if (fire_in && k_last)         state_n = S_TAIL;
         S_TAIL:  if (fire_in && t == 2'd2)      state_n = S_FLUSH;
         S_FLUSH: if (out_fire && out_last)      state_n = S_DATA;
         default:                                state_n = S_DATA;
      endcase
   end

   always_comb begin
      in_ready = (state != S_FLUSH) && (cnt <= 5'd11);
   end

   always_ff @(posedge clk) begin
      if (!rst_N) begin
         k         <= '0;
         t         <= '0;
         acc       <= '0;
         cnt       <= '0;
         out_valid <= 1'b0;
         out_data  <= 8'h00;
         out_last  <= 1'b0;
         err       <= 1'b0;
      end else begin
         acc <= acc_n;
         cnt <= cnt_n;
         if (state == S_FLUSH && out_fire && out_last) begin
            k <= '0;
            t <= '0;
         end else if (fire_in && state == S_DATA) begin
            k <= k + 1'b1;
         end else if (fire_in && state == S_TAIL) begin
            t <= t + 1'b1;
         end
         if (ld) begin
            out_valid <= 1'b1;
            out_data  <= ld_data;
            out_last  <= ld_last;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
         if (fire_in && (in_mode != (state == S_TAIL))) err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_turbo_out_mux.sv
// Bench for turbo_out_mux: three block sizes, directed and random
// streams checked against a bit-queue packing model.
module tb_turbo_out_mux;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_N;
   logic       in_valid  [3];
   logic       in_mode   [3];
   logic       x1        [3];
   logic       z1        [3];
   logic       x2        [3];
   logic       z2        [3];
   logic       out_ready [3];
   logic       in_ready  [3];
   logic       out_valid [3];
   logic       out_last  [3];
   logic       err       [3];
   logic [7:0] out_data  [3];

   turbo_out_mux #(.K(4)) u_k4 (
      .clk(clk), .rst_N(rst_N),
      .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_mode(in_mode[0]),
      .x1(x1[0]), .z1(z1[0]), .x2(x2[0]), .z2(z2[0]),
      .out_valid(out_valid[0]), .out_ready(out_ready[0]),
      .out_data(out_data[0]), .out_last(out_last[0]), .err(err[0])
   );

   turbo_out_mux #(.K(8)) u_k8 (
      .clk(clk), .rst_N(rst_N),
      .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_mode(in_mode[1]),
      .x1(x1[1]), .z1(z1[1]), .x2(x2[1]), .z2(z2[1]),
      .out_valid(out_valid[1]), .out_ready(out_ready[1]),
      .out_data(out_data[1]), .out_last(out_last[1]), .err(err[1])
   );

   turbo_out_mux #(.K(40)) u_k40 (
      .clk(clk), .rst_N(rst_N),
      .in_valid(in_valid[2]), .in_ready(in_ready[2]), .in_mode(in_mode[2]),
      .x1(x1[2]), .z1(z1[2]), .x2(x2[2]), .z2(z2[2]),
      .out_valid(out_valid[2]), .out_ready(out_ready[2]),
      .out_data(out_data[2]), .out_last(out_last[2]), .err(err[2])
   );

   int         n_chk = 0;
   int         n_err = 0;
   int         or_mode [3];
   logic [8:0] cap [3][$];
   logic [4:0] bq[$];
   logic [8:0] exp_q[$];

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] want);
      n_chk++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, want);
      end
   endtask

   function automatic int kof(input int d);
      return (d == 0) ? 4 : ((d == 1) ? 8 : 40);
   endfunction

   always @(posedge clk) begin
      #1;
      for (int d = 0; d < 3; d++) begin
         case (or_mode[d])
            0:       out_ready[d] = 1'b1;
            1:       out_ready[d] = 1'($urandom_range(0, 1));
            default: out_ready[d] = 1'b0;
         endcase
      end
   end

   always @(negedge clk) begin
      if (rst_N === 1'b1) begin
         for (int d = 0; d < 3; d++)
            if (out_valid[d] && out_ready[d])
               cap[d].push_back({out_last[d], out_data[d]});
      end
   end

   // beat = {mode, x1, z1, x2, z2}; pat 0 all ones, 1 fixed, 2 random
   task automatic gen(input int kk, input int pat, input int bad);
      logic       m;
      logic [3:0] b;
      bq.delete();
      for (int i = 0; i < kk + 3; i++) begin
         m = (i >= kk);
         if (i == bad) m = ~m;
         case (pat)
            0:       b = 4'hF;
            1:       b = (i >= kk) ? 4'b1100 : 4'b1001;
            default: b = 4'($urandom_range(0, 15));
         endcase
         bq.push_back({m, b});
      end
   endtask

   task automatic model(input int kk);
      bit         bits[$];
      logic [7:0] w;
      int         nw;
      exp_q.delete();
      for (int i = 0; i < bq.size(); i++) begin
         bits.push_back(bq[i][3]);
         bits.push_back(bq[i][2]);
         if (i >= kk) bits.push_back(bq[i][1]);
         bits.push_back(bq[i][0]);
      end
      nw = (bits.size() + 7) / 8;
      for (int j = 0; j < nw; j++) begin
         w = 8'h00;
         for (int b = 0; b < 8; b++)
            if (8 * j + b < bits.size()) w[7-b] = bits[8*j+b];
         exp_q.push_back({(j == nw - 1), w});
      end
   endtask

   task automatic drive(input int d, input int lo, input int hi,
                        input bit gap);
      bit ok;
      int cyc;
      for (int i = lo; i <= hi; i++) begin
         if (gap) begin
            in_valid[d] = 1'b0;
            repeat ($urandom_range(0, 2)) begin
               @(posedge clk);
               #1;
            end
         end
         in_valid[d] = 1'b1;
         in_mode[d]  = bq[i][4];
         x1[d]       = bq[i][3];
         z1[d]       = bq[i][2];
         x2[d]       = bq[i][1];
         z2[d]       = bq[i][0];
         ok  = 1'b0;
         cyc = 0;
         while (!ok && cyc < 200) begin
            @(negedge clk);
            ok = in_ready[d];
            @(posedge clk);
            #1;
            cyc++;
         end
         if (!ok) chk("in_ready_timeout", 0, 1);
      end
      in_valid[d] = 1'b0;
   endtask

   task automatic check_block(input int d, input string tag,
                              input bit use_model);
      int cyc = 0;
      if (use_model) model(kof(d));
      while (cap[d].size() < exp_q.size() && cyc < 2000) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      repeat (8) begin
         @(posedge clk);
         #1;
      end
      chk({tag, "_nwords"}, cap[d].size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < cap[d].size(); i++)
         chk($sformatf("%s_w%0d", tag, i), cap[d][i], exp_q[i]);
      cap[d].delete();
   endtask

   task automatic set_k8_const();
      exp_q.delete();
      exp_q.push_back(9'h0B6);
      exp_q.push_back(9'h0DB);
      exp_q.push_back(9'h06D);
      exp_q.push_back(9'h0CC);
      exp_q.push_back(9'h1C0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int n;
      bit saw_low;
      for (int d = 0; d < 3; d++) begin
         or_mode[d]   = 0;
         out_ready[d] = 1'b1;
         in_valid[d]  = 1'b0;
         in_mode[d]   = 1'b0;
         x1[d] = 1'b0; z1[d] = 1'b0; x2[d] = 1'b0; z2[d] = 1'b0;
      end
      rst_N = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst_N = 1'b1;
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
         chk($sformatf("rst_ov%0d", d), out_valid[d], 0);
         chk($sformatf("rst_od%0d", d), out_data[d], 8'h00);
         chk($sformatf("rst_ol%0d", d), out_last[d], 0);
         chk($sformatf("rst_err%0d", d), err[d], 0);
         chk($sformatf("rst_ir%0d", d), in_ready[d], 1);
      end
      @(posedge clk);
      #1;

      gen(4, 0, -1);
      drive(0, 0, 6, 1'b0);
      exp_q.delete();
      exp_q.push_back(9'h0FF);
      exp_q.push_back(9'h0FF);
      exp_q.push_back(9'h1FF);
      check_block(0, "k4_ones", 1'b0);
      chk("k4_ones_err", err[0], 0);

      gen(8, 1, -1);
      fork
         drive(1, 0, 10, 1'b0);
         begin
            n = 0;
            do begin
               @(posedge clk);
               n++;
               @(negedge clk);
            end while (!out_valid[1] && n < 20);
            chk("k8_latency", n, 4);
         end
      join
      set_k8_const();
      check_block(1, "k8_pat", 1'b0);
      chk("k8_pat_err", err[1], 0);

      or_mode[1] = 2;
      gen(8, 1, -1);
      fork
         drive(1, 0, 10, 1'b0);
         begin
            saw_low = 1'b0;
            repeat (20) begin
               @(negedge clk);
               if (!in_ready[1]) saw_low = 1'b1;
            end
            chk("bp_in_ready_fell", saw_low, 1);
            chk("bp_in_ready_low", in_ready[1], 0);
            chk("bp_hold_valid", out_valid[1], 1);
            chk("bp_hold_data", out_data[1], 8'hB6);
            chk("bp_no_words", cap[1].size(), 0);
            @(posedge clk);
            #1;
            or_mode[1] = 0;
         end
      join
      set_k8_const();
      check_block(1, "bp", 1'b0);

      gen(4, 0, 1);
      drive(0, 0, 0, 1'b0);
      @(negedge clk);
      chk("perr_before", err[0], 0);
      @(posedge clk);
      #1;
      drive(0, 1, 1, 1'b0);
      @(negedge clk);
      chk("perr_set", err[0], 1);
      @(posedge clk);
      #1;
      drive(0, 2, 6, 1'b0);
      exp_q.delete();
      exp_q.push_back(9'h0FF);
      exp_q.push_back(9'h0FF);
      exp_q.push_back(9'h1FF);
      check_block(0, "perr", 1'b0);
      chk("perr_sticky", err[0], 1);

      gen(8, 1, -1);
      drive(1, 0, 4, 1'b0);
      rst_N = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_N = 1'b1;
      cap[1].delete();
      @(negedge clk);
      chk("mrst_ov", out_valid[1], 0);
      chk("mrst_err0", err[0], 0);
      @(posedge clk);
      #1;
      drive(1, 0, 10, 1'b0);
      set_k8_const();
      check_block(1, "mrst", 1'b0);
      chk("mrst_err", err[1], 0);

      for (int r = 0; r < 12; r++) begin
         int d;
         d = r % 3;
         or_mode[d] = 1;
         gen(kof(d), 2, -1);
         drive(d, 0, kof(d) + 2, 1'b1);
         check_block(d, $sformatf("rnd%0d", r), 1'b1);
         chk($sformatf("rnd%0d_err", r), err[d], 0);
         or_mode[d] = 0;
      end

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/turbo_out_mux.md
# turbo_out_mux

Output multiplexer and byte packer for the turbo encoder. It sits directly downstream of the two constituent RSC encoders and takes one systematic bit plus two parity bits per data cycle, and the tail pairs from both encoders during termination. It serialises the rate-1/3 codeword of 3K+12 bits into 8-bit words under a valid/ready handshake. It zero-pads the final word and marks it with `out_last`.

## Interface
- `K`, 40: block length in information bits; K ≥ 1.
- `clk` input 1: clock, all state updates on rising edge.
- `rst_N` input 1: reset, synchronous, active-low.
- `in_valid` input 1: input beat valid.
- `in_ready` output 1: beat accepted when `in_valid && in_ready`.
- `in_mode` input 1: encoder mode; 0 means data, 1 means termination/tail.
- `x1` input 1: systematic bit from encoder 1. In tail phase it is encoder 1's tail x.
- `z1` input 1: parity from encoder 1.
- `x2` input 1: encoder 2's tail x. It is used in tail phase only.
- `z2` input 1: parity from encoder 2, fed with interleaved data.
- `out_valid` output 1: `out_data` valid.
- `out_ready` input 1: downstream accepts the word.
- `out_data` output 8: packed word; the first serial bit is in bit 7.
- `out_last` output 1: marks the final word of the block.
- `err` output 1: sticky protocol-error flag.

## Operation
- Phase FSM states:
  - DATA, with counter k from 0 to K-1.
  - TAIL, with counter t from 0 to 2.
  - FLUSH.
- FSM transitions:
  - DATA moves to TAIL on the accepted beat with k=K-1.
  - TAIL moves to FLUSH on the accepted beat with t=2.
  - FLUSH moves to DATA, with all counters cleared, on the handshake of the word with `out_last`=1.
- The phase is determined only by the internal counters. `in_mode` is checked but never used for steering.
- Bits pushed per accepted beat, in serial order:
  - DATA: 3 bits, x1, z1, z2.
  - TAIL: 4 bits, x1, z1, x2, z2.
- Bit buffer:
  - 16-bit accumulator `acc`, left-aligned, with occupancy `cnt` (5 bits, 0–15).
  - The oldest bit is at `acc[15]`.
- `in_ready` = (state != FLUSH) && (cnt ≤ 11). It is derived only from registered state, with no combinational path from `out_ready`.
- Word load happens when the output slot is free, i.e. `!out_valid || out_ready`.
  - If cnt ≥ 8: load `acc[15:8]` and remove 8 bits.
  - Else, if state = FLUSH and cnt > 0: load the remaining bits left-aligned, zero-pad the low bits, and set cnt to 0.
- `out_last` = 1 for a word loaded in FLUSH with pre-load cnt ≤ 8. That word consumes all remaining bits.
- A simultaneous load and push in one cycle is allowed:
  - Evaluate the load on the pre-edge `acc`/`cnt`.
  - Shift the remainder up.
  - Append the new bits directly after it.
  - New cnt = cnt − popped + pushed.
- FLUSH is always entered with cnt ≥ 4, so the final word is always loaded in FLUSH.
- `err` is set when an accepted beat has `in_mode` ≠ expected, where expected is 0 in DATA and 1 in TAIL. It is cleared only by reset.

## Timing
- Reset (rst_N=0 at a clock edge) sets:
  - state=DATA, k=t=0.
  - acc=0, cnt=0.
  - out_valid=0, out_data=0x00, out_last=0, err=0.
- Consequently `in_ready`=1 on the first cycle after reset.
- Reset mid-block discards all buffered bits and any pending word. No `out_last` is emitted for the aborted block.
- Latency from the first accepted beat to `out_valid`=1:
  - With back-to-back input, cnt is 9 after the 3rd beat.
  - The word loads on the 4th edge, so `out_valid` rises 4 cycles after the first beat.
- While `out_valid && !out_ready`, `out_data` and `out_last` are held stable.
- Sustained throughput with `out_ready`=1: 3 bits/cycle in, one word every ≤ 3 cycles. The buffer must never overflow.
- Word count per block is ceil((3K+12)/8). For K=40 this is 17 words; the last word carries 4 valid bits and 4 zero bits.
- In FLUSH, `in_ready`=0. A new block can be accepted on the cycle after the last-word handshake.

## Test plan
- Reset: hold rst_N=0 for 3 cycles, then release.
  - Required: out_valid=0, out_data=0x00, out_last=0, err=0, in_ready=1.
- K=4, all inputs 1, in_mode correct, out_ready=1.
  - Required: exactly 3 words, 0xFF 0xFF 0xFF, with out_last only on the 3rd and err=0.
- K=8, data beats x1=1 z1=0 z2=1, tail beats x1=1 z1=1 x2=0 z2=0.
  - Required: 0xB6 0xDB 0x6D 0xCC 0xC0, with out_last on 0xC0.
- Backpressure, K=8 stream from the previous test:
  - out_ready=0 for 20 cycles. Required: in_ready falls once cnt > 11, and out_data is held at 0xB6.
  - Then release out_ready. Required: the identical 5-word sequence with no lost or duplicated bits.
- Protocol error, K=4: drive in_mode=1 on data beat 2.
  - Required: err=1 after that edge and stays set.
  - Required: the output stream is unchanged, still 3 words.
- Reset mid-block, K=8:
  - Apply rst_N=0 after 5 beats, then run a full clean block.
  - Required: only the 5 words from the K=8 test appear, err=0.
